// File: rtl/int_gen_if.sv
// Store/read bus between the Bridge interrupt-generator window and int_gen.
//   Addr : physical byte address
//   WE   : byte enables, nonzero means store
//   Din  : store data
//   Dout : combinational read data for Addr
// master = Bridge side, slave = int_gen side.
interface int_gen_if;
   logic [31:0] Addr;
   logic [3:0]  WE;
   logic [31:0] Din;
   logic [31:0] Dout;

   modport master (output Addr, output WE, output Din, input Dout);
   modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/int_gen.sv
// Programmable interrupt source behind a 16-byte register window at BASE.
// A down-counter reloaded from PERIOD raises a level IRQ (the pending flag),
// one-shot or periodic, until software stores to the ACK word. Fires that
// land on an already-pending interrupt are counted in a saturating MISS.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : int_gen_if.slave (Addr, WE, Din in; Dout out)
//   IRQ   : registered level interrupt, equals pending
//
// Word map (Addr[3:2]):
//   0 ACK    W   any store clears pending, reads 0
//   1 CTRL   R/W [0] EN, [1] PERIODIC, written only by WE[0]
//   2 PERIOD R/W byte-enabled reload value
//   3 STAT   R   [0] pending, [15:8] MISS; any store here clears MISS
module int_gen #(
   parameter logic [31:0] BASE = 32'h0000_7F20
) (
   input  logic     clk,
   input  logic     reset,
   int_gen_if.slave bus,
   output logic     IRQ
);

   logic        en_q, en_d;
   logic        per_q, per_d;
   logic [31:0] period_q, period_d;
   logic [31:0] count_q, count_d;
   logic        pend_q, pend_d;
   logic [7:0]  miss_q, miss_d;

   logic        hit, store;
   logic [1:0]  word;
   logic        ack_st, ctrl_st, period_st, stat_st;
   logic        fire;
   logic        unused_addr;

   assign hit         = (bus.Addr[31:4] == BASE[31:4]);
   assign word        = bus.Addr[3:2];
   assign store       = hit && (bus.WE != 4'd0);
   assign ack_st      = store && (word == 2'd0);
   assign ctrl_st     = store && (word == 2'd1) && bus.WE[0];
   assign period_st   = store && (word == 2'd2);
   assign stat_st     = store && (word == 2'd3);
   assign unused_addr = ^bus.Addr[1:0];

   // Fire is decided purely from pre-edge state; a coincident CTRL store
   // still lets this fire set pending, it only overrides EN/COUNT.
   assign fire = en_q && (count_q == 32'd0);

   always_comb begin
      en_d     = en_q;
      per_d    = per_q;
      period_d = period_q;
      count_d  = count_q;
      pend_d   = pend_q;
      miss_d   = miss_q;

      if (ctrl_st) begin
         en_d  = bus.Din[0];
         per_d = bus.Din[1];
         if (bus.Din[0]) begin
            count_d = period_q;
         end
      end else if (en_q) begin
         if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
         end else if (per_q) begin
            count_d = period_q;
         end else begin
            en_d = 1'b0;
         end
      end

      if (period_st) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.WE[i]) begin
               period_d[8*i +: 8] = bus.Din[8*i +: 8];
            end
         end
      end

      // Fire beats a simultaneous ACK.
      if (fire) begin
         pend_d = 1'b1;
      end else if (ack_st) begin
         pend_d = 1'b0;
      end

      if (stat_st) begin
         miss_d = 8'd0;
      end else if (fire && pend_q && !ack_st && (miss_q != 8'hFF)) begin
         miss_d = miss_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q     <= 1'b0;
         per_q    <= 1'b0;
         period_q <= 32'd0;
         count_q  <= 32'd0;
         pend_q   <= 1'b0;
         miss_q   <= 8'd0;
      end else begin
         en_q     <= en_d;
         per_q    <= per_d;
         period_q <= period_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         miss_q   <= miss_d;
      end
   end

   always_comb begin
      bus.Dout = 32'd0;
      if (hit) begin
         case (word)
            2'd1:    bus.Dout = {30'd0, per_q, en_q};
            2'd2:    bus.Dout = period_q;
            2'd3:    bus.Dout = {16'd0, miss_q, 7'd0, pend_q};
            default: bus.Dout = 32'd0;
         endcase
      end
   end

   assign IRQ = pend_q;

endmodule

// File: tb/tb_int_gen.sv
module tb_int_gen;

   localparam logic [31:0] BASE = 32'h0000_7F20;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic IRQ;

   int_gen_if bif();

   int_gen #(.BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the timer is tracked as the absolute edge number of
   // the next fire rather than as a counter.
   longint      m_edge;
   longint      m_next;
   logic        m_en, m_per, m_pend;
   logic [31:0] m_period;
   int          m_miss;

   function automatic void model_reset();
      m_edge = 0; m_next = 0; m_en = 0; m_per = 0; m_pend = 0;
      m_period = 0; m_miss = 0;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      logic [31:0] r;
      r = 0;
      if (a[31:4] == BASE[31:4]) begin
         case (a[3:2])
            2'd1: r = {30'd0, m_per, m_en};
            2'd2: r = m_period;
            2'd3: r = (m_miss << 8) | {31'd0, m_pend};
            default: r = 0;
         endcase
      end
      return r;
   endfunction

   function automatic void model_edge(input logic [31:0] a, input logic [3:0] w,
                                      input logic [31:0] d);
      bit st, ack, stat, fire;
      int wd;
      st   = (a[31:4] == BASE[31:4]) && (w != 0);
      wd   = int'(a[3:2]);
      ack  = st && wd == 0;
      stat = st && wd == 3;
      fire = m_en && (m_next == m_edge);
      if (fire) begin
         if (m_pend && !ack && m_miss < 255) m_miss++;
         m_pend = 1;
         if (m_per) m_next = m_edge + longint'(m_period) + 1;
         else m_en = 0;
      end else if (ack) begin
         m_pend = 0;
      end
      if (st && wd == 1 && w[0]) begin
         m_en  = d[0];
         m_per = d[1];
         if (d[0]) m_next = m_edge + longint'(m_period) + 1;
      end
      if (st && wd == 2) begin
         for (int i = 0; i < 4; i++)
            if (w[i]) m_period[8*i +: 8] = d[8*i +: 8];
      end
      if (stat) m_miss = 0;
      m_edge++;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock with the given bus values; checks IRQ and readback after the edge.
   task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      bif.Addr = a; bif.WE = w; bif.Din = d;
      @(posedge clk);
      model_edge(a, w, d);
      #1;
      chk("irq", {31'd0, IRQ}, {31'd0, m_pend});
      chk("dout", bif.Dout, model_rd(a));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(BASE + 32'hC, 4'd0, 32'd0);
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bif.Addr = a; bif.WE = 4'd0;
      #1;
      chk(tag, bif.Dout, exp);
   endtask

   task automatic rand_op();
      logic [31:0] a, d;
      logic [3:0]  w;
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
         0, 1:    a = BASE;
         2, 3:    a = BASE + 32'h4;
         4, 5:    a = BASE + 32'h8;
         6:       a = BASE + 32'hC;
         7:       a = BASE + 32'h10;
         8:       a = BASE - 32'h4;
         default: a = BASE + 32'hC;
      endcase
      w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (sel == 4 || sel == 5) d = 32'($urandom_range(0, 6));
      else d = $urandom;
      bus(a, w, d);
   endtask

   initial begin
      bif.Addr = 0; bif.WE = 0; bif.Din = 0;
      model_reset();

      // Reset held with bus activity.
      for (int i = 0; i < 6; i++) begin
         bif.Addr = BASE + 32'($urandom_range(0, 3) * 4);
         bif.WE   = 4'($urandom_range(0, 15));
         bif.Din  = $urandom;
         @(posedge clk);
         #1;
         chk("rst_irq", {31'd0, IRQ}, 32'd0);
      end
      peek("rst_stat", BASE + 32'hC, 32'd0);
      peek("rst_ctrl", BASE + 32'h4, 32'd0);
      peek("rst_period", BASE + 32'h8, 32'd0);
      bif.WE = 0;
      @(negedge clk);
      reset = 1'b1;

      // One-shot, PERIOD=5.
      bus(BASE + 32'h8, 4'hF, 32'd5);
      bus(BASE + 32'h4, 4'h1, 32'h1);
      idle(5);
      chk("oneshot_pre", {31'd0, IRQ}, 32'd0);
      idle(1);
      chk("oneshot_fire", {31'd0, IRQ}, 32'd1);
      bus(BASE + 32'h4, 4'h0, 32'd0);
      chk("oneshot_ctrl", bif.Dout, 32'd0);
      idle(2);
      bus(BASE, 4'hF, 32'd0);
      chk("oneshot_ack", {31'd0, IRQ}, 32'd0);
      idle(20);
      chk("oneshot_quiet", {31'd0, IRQ}, 32'd0);

      // Periodic with misses.
      bus(BASE + 32'h8, 4'hF, 32'd3);
      bus(BASE + 32'h4, 4'h1, 32'h3);
      idle(12);
      chk("periodic_stat", bif.Dout, 32'h0000_0201);
      idle(1200);
      chk("miss_sat", bif.Dout, 32'h0000_FF01);
      bus(BASE + 32'hC, 4'hF, 32'd0);
      chk("miss_clear", bif.Dout, 32'h0000_0001);
      bus(BASE + 32'h4, 4'h1, 32'h0);
      bus(BASE, 4'h1, 32'd0);

      // Byte enables.
      bus(BASE + 32'h8, 4'hF, 32'hAABB_CCDD);
      bus(BASE + 32'h8, 4'b0101, 32'h1122_3344);
      chk("period_bytes", bif.Dout, 32'hAA22_CC44);
      bus(BASE + 32'h4, 4'b0010, 32'h1);
      chk("ctrl_we0_only", bif.Dout, 32'd0);

      // Collisions with PERIOD=0.
      bus(BASE + 32'h8, 4'hF, 32'd0);
      bus(BASE + 32'h4, 4'h1, 32'h3);
      for (int i = 0; i < 10; i++) begin
         bus(BASE, 4'hF, 32'd0);
         chk("ack_vs_fire", {31'd0, IRQ}, 32'd1);
      end
      peek("ack_nomiss", BASE + 32'hC, 32'h0000_0001);
      bus(BASE + 32'h4, 4'h1, 32'h0);
      chk("ctrl_vs_fire_irq", {31'd0, IRQ}, 32'd1);
      chk("ctrl_vs_fire_en", bif.Dout, 32'd0);
      bus(BASE, 4'hF, 32'd0);
      idle(5);
      chk("no_refire", {31'd0, IRQ}, 32'd0);

      // Decode.
      bus(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
      chk("miss_hi", bif.Dout, 32'd0);
      bus(BASE - 32'h4, 4'hF, 32'hFFFF_FFFF);
      chk("miss_lo", bif.Dout, 32'd0);
      peek("ack_read", BASE, 32'd0);
      peek("decode_period", BASE + 32'h8, m_period);
      peek("decode_ctrl", BASE + 32'h4, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) rand_op();

      // Asynchronous reset while IRQ is high.
      bus(BASE + 32'h8, 4'hF, 32'd0);
      bus(BASE + 32'h4, 4'h1, 32'h1);
      idle(2);
      chk("pre_async_irq", {31'd0, IRQ}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_drop", {31'd0, IRQ}, 32'd0);
      peek("async_stat", BASE + 32'hC, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/int_gen.md
# int_gen

Programmable interrupt source that sits behind the Bridge's interrupt-generator window, on the responder side of the `m_int_addr` / `m_int_byteen` store path. The CPU programs it through byte-enabled stores and acknowledges it with a store to the ACK word. It raises a level interrupt on `IRQ` after a programmed number of cycles, one-shot or periodic, and holds it until acknowledged. `IRQ` feeds the `interrupt` input of `mips`. Missed firings are counted for software diagnosis.

## Interface
Parameters:
- `BASE`, default 32'h0000_7F20: byte address of the 16-byte register window. `BASE[3:0]` must be 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Deassertion is taken on the next `clk` edge.
- `Addr`  in  32  physical byte address from the Bridge (`DEV_ADDR`).
- `WE`  in  4  byte enables. Any nonzero value is a store; `WE[i]` enables `Din[8i+7:8i]`.
- `Din`  in  32  store data.
- `Dout`  out  32  combinational read data for `Addr`.
- `IRQ`  out  1  level interrupt; equals the pending flag.

## Operation
- Hit: `Addr[31:4] == BASE[31:4]`. The word is selected by `Addr[3:2]`.
- On a miss, stores are ignored and `Dout` = 0.
- Registers (offset: name, access, content):
  - +0x0: ACK, W. A store with any `WE` bit set clears pending. Reads return 0, which preserves the existing read-as-zero rule for this address.
  - +0x4: CTRL, R/W. [0] EN, [1] PERIODIC; [31:2] read 0.
    - Only `WE[0]` updates CTRL.
    - Such a store with `Din[0]`=1 also loads COUNT←PERIOD (restart), even if EN was already 1.
  - +0x8: PERIOD, R/W, 32 bit. Updated per byte under `WE`. Affects only the next load.
  - +0xC: STAT, R. [0] pending, [15:8] MISS (8 bit); others 0. Any store clears MISS.
- COUNT: 32-bit internal register, not readable. Each edge with EN=1 and no CTRL restart store:
  - If COUNT != 0: COUNT←COUNT−1.
  - If COUNT == 0: fire.
    - pending←1.
    - If PERIODIC, COUNT←PERIOD.
    - Otherwise EN←0.
- EN=0: COUNT holds and nothing fires.
- MISS: incremented on a fire while pending is already 1. Saturates at 8'hFF.
- Simultaneous events at one edge. Fire is evaluated from pre-edge state.
  - Fire + ACK store: pending=1 (fire wins). MISS is not incremented.
  - Fire + CTRL store: the fire still sets pending. EN/PERIODIC/COUNT take the stored values. The CTRL store overrides the fire's reload or EN clear.
  - Fire + STAT store: MISS←0. No increment that cycle.
- Unused `Din` bits are ignored.

## Timing
- Reset values: `IRQ`=0, EN=0, PERIODIC=0, PERIOD=0, COUNT=0, pending=0, MISS=0.
  - `Dout` reflects the reset registers combinationally.
  - Reset mid-countdown or while `IRQ` is high drops `IRQ` asynchronously, with no clock needed.
- Store latency: registers are updated at the edge where `WE` is nonzero. Reads see new values in the following cycle.
- Countdown (CTRL store EN=1 at edge E0, PERIOD=N):
  - COUNT=N after E0 and reaches 0 after edge E0+N.
  - `IRQ` rises after edge E0+N+1.
  - N=0 gives `IRQ` high after E0+1.
- Periodic mode: a fire every N+1 cycles. N=0 fires every cycle.
- ACK at edge A: `IRQ` low after A, unless a fire coincides at A.
- `IRQ` is registered and glitch-free. It has no combinational path from `Addr`/`WE`.

## Test plan
- Reset check: hold `reset`=0 with random bus activity → `IRQ`=0, STAT/CTRL/PERIOD read 0. Pull `reset` low while `IRQ`=1 → `IRQ` drops before the next edge.
- One-shot: PERIOD=5, then CTRL=0x1 at edge E0 → `IRQ` high after E0+6 and stays high.
  - CTRL reads 0x0 (EN cleared).
  - ACK at E0+10 → `IRQ`=0 and never re-fires.
- Periodic + miss: PERIOD=3, CTRL=0x3, no ACK → fires at E0+4, 8, 12.
  - STAT reads 0x0201 after the third fire.
  - Run 300 fires → MISS saturates at 0xFF. A STAT store → 0x0001.
- Byte-enable: PERIOD store 0xAABBCCDD with `WE`=4'b1111, then 0x11223344 with `WE`=4'b0101 → PERIOD reads 0xAA22CC44.
  - CTRL store with `WE`=4'b0010, `Din`=1 → CTRL unchanged (0).
- Collisions, periodic PERIOD=0:
  - ACK every cycle → `IRQ` stays 1 and MISS stays 0.
  - A CTRL store of 0x0 coinciding with a fire → pending=1, EN=0, no further fires.
- Decode: stores to BASE+0x10 and BASE−4 with `WE`=4'hF → no state change, `Dout`=0. Reading BASE+0x0 → 0.
